// File: rtl/writeback_arbiter_if.sv
// Writeback bus bundle: ALU result, load handshake, register-file write port and hazard lookup.
// The slave modport is the arbiter's view; master is the surrounding pipeline's view.
interface writeback_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned LQ_DEPTH   = 4
);
  localparam int unsigned AW = $clog2(REG_COUNT);
  localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;

  logic                  alu_valid;
  logic [AW-1:0]         alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;

  logic                  ld_valid;
  logic                  ld_ready;
  logic [AW-1:0]         ld_rd;
  logic [DATA_WIDTH-1:0] ld_data;

  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  reg_write_en;

  logic [AW-1:0]         chk_addr;
  logic                  chk_pending;
  logic [CW-1:0]         lq_count;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output chk_addr,
    input  ld_ready, rd_addr, rd_data, reg_write_en, chk_pending, lq_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  chk_addr,
    output ld_ready, rd_addr, rd_data, reg_write_en, chk_pending, lq_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: ALU results win the register-file port; load results wait in an in-order
// queue, drained when the ALU is idle. Younger ALU writes squash queued loads to the same rd.
module writeback_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned LQ_DEPTH   = 4
) (
  input logic                clk,
  input logic                rst_n,
  writeback_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(REG_COUNT);
  localparam int unsigned PW = $clog2(LQ_DEPTH);
  localparam int unsigned CW = PW + 1;

  // Queue storage; live bit is cleared on pop, so it also marks occupancy.
  logic [AW-1:0]         r_q_rd   [LQ_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_data [LQ_DEPTH];
  logic [LQ_DEPTH-1:0]   r_q_live;
  logic [LQ_DEPTH-1:0]   w_q_live_d;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_d;
  logic                  r_ready_en;

  logic                  r_we;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  w_we_d;
  logic [AW-1:0]         w_addr_d;
  logic [DATA_WIDTH-1:0] w_data_d;

  logic w_ld_ready;
  logic w_push;
  logic w_enq;
  logic w_alu_wr;
  logic w_pop;
  logic w_head_live;
  logic w_hit;

  // ld_ready depends only on registered state, never on this cycle's pop.
  assign w_ld_ready  = r_ready_en && (r_count < CW'(LQ_DEPTH));
  assign w_push      = bus.ld_valid && w_ld_ready;
  assign w_enq       = w_push && (bus.ld_rd != '0);
  assign w_alu_wr    = bus.alu_valid && (bus.alu_rd != '0);
  assign w_pop       = !w_alu_wr && (r_count != '0);
  assign w_head_live = r_q_live[r_rptr];
  assign w_count_d   = r_count + CW'(w_enq) - CW'(w_pop);

  always_comb begin
    w_q_live_d = r_q_live;
    if (w_alu_wr) begin
      for (int i = 0; i < int'(LQ_DEPTH); i++) begin
        if (r_q_rd[i] == bus.alu_rd) begin
          w_q_live_d[i] = 1'b0;
        end
      end
    end
    if (w_pop) begin
      w_q_live_d[r_rptr] = 1'b0;
    end
    // Applied last: a same-cycle push to the ALU's rd is younger and must stay live.
    if (w_enq) begin
      w_q_live_d[r_wptr] = 1'b1;
    end
  end

  always_comb begin
    w_we_d   = 1'b0;
    w_addr_d = r_addr;
    w_data_d = r_data;
    if (w_alu_wr) begin
      w_we_d   = 1'b1;
      w_addr_d = bus.alu_rd;
      w_data_d = bus.alu_data;
    end else if (w_pop && w_head_live) begin
      w_we_d   = 1'b1;
      w_addr_d = r_q_rd[r_rptr];
      w_data_d = r_q_data[r_rptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_live   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_q_live   <= w_q_live_d;
      r_count    <= w_count_d;
      r_ready_en <= 1'b1;
      r_we       <= w_we_d;
      r_addr     <= w_addr_d;
      r_data     <= w_data_d;
      if (w_enq) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Payload needs no reset: only slots with the live bit set are ever read out.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_rd[r_wptr]   <= bus.ld_rd;
      r_q_data[r_wptr] <= bus.ld_data;
    end
  end

  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < int'(LQ_DEPTH); i++) begin
      if (r_q_live[i] && (r_q_rd[i] == bus.chk_addr)) begin
        w_hit = 1'b1;
      end
    end
  end

  assign bus.chk_pending  = (bus.chk_addr != '0) &&
                            (w_hit || (r_we && (r_addr == bus.chk_addr)));
  assign bus.ld_ready     = w_ld_ready;
  assign bus.lq_count     = r_count;
  assign bus.reg_write_en = r_we;
  assign bus.rd_addr      = r_addr;
  assign bus.rd_data      = r_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios then random traffic, compared against a
// queue-based reference model of the writeback rules.
module tb_writeback_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned RC = 32;
  localparam int unsigned LQ = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  logic clk;
  logic rst_n;

  writeback_arbiter_if #(.DATA_WIDTH(DW), .REG_COUNT(RC), .LQ_DEPTH(LQ)) bus ();

  writeback_arbiter #(.DATA_WIDTH(DW), .REG_COUNT(RC), .LQ_DEPTH(LQ)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_ready_en;
  bit          m_pushed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_we       = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_ready_en = 1'b0;
  endtask

  // One clock cycle: drive, check combinational outputs, advance model, check registered outputs.
  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] ca);
    bit   exp_ready;
    bit   exp_pend;
    ent_t e;
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = ad;
    bus.ld_valid  = lv;
    bus.ld_rd     = lrd;
    bus.ld_data   = ldat;
    bus.chk_addr  = ca;
    #1;
    exp_ready = m_ready_en && (mq.size() < LQ);
    exp_pend  = 1'b0;
    if (ca != 0) begin
      foreach (mq[i]) if (mq[i].live && mq[i].rd == ca) exp_pend = 1'b1;
      if (m_we && m_addr == ca) exp_pend = 1'b1;
    end
    check("ld_ready", 64'(bus.ld_ready), 64'(exp_ready));
    check("lq_count", 64'(bus.lq_count), 64'(mq.size()));
    check("chk_pending", 64'(bus.chk_pending), 64'(exp_pend));

    m_pushed = lv && exp_ready;
    if (av && ard != 0) begin
      foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
      m_we   = 1'b1;
      m_addr = ard;
      m_data = ad;
    end else if (mq.size() > 0) begin
      e    = mq.pop_front();
      m_we = e.live;
      if (e.live) begin
        m_addr = e.rd;
        m_data = e.data;
      end
    end else begin
      m_we = 1'b0;
    end
    if (m_pushed && lrd != 0) begin
      e.rd   = lrd;
      e.data = ldat;
      e.live = 1'b1;
      mq.push_back(e);
    end
    m_ready_en = 1'b1;

    @(posedge clk);
    #1;
    check("reg_write_en", 64'(bus.reg_write_en), 64'(m_we));
    check("rd_addr", 64'(bus.rd_addr), 64'(m_addr));
    check("rd_data", 64'(bus.rd_data), 64'(m_data));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [4:0] ca);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ca);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_we", 64'(bus.reg_write_en), 64'd0);
    check("rst_addr", 64'(bus.rd_addr), 64'd0);
    check("rst_data", 64'(bus.rd_data), 64'd0);
    check("rst_count", 64'(bus.lq_count), 64'd0);
    check("rst_ready", 64'(bus.ld_ready), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    rst_n = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;
    bus.chk_addr  = '0;
    model_reset();
    #1;
    check("init_we", 64'(bus.reg_write_en), 64'd0);
    check("init_count", 64'(bus.lq_count), 64'd0);
    check("init_ready", 64'(bus.ld_ready), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1, 5'd0);

    // Single ALU write, visible one cycle later, gone the cycle after.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd0);
    check("alu_data_const", 64'(bus.rd_data), 64'hDEADBEEF);
    idle(1, 5'd0);
    check("alu_we_drop", 64'(bus.reg_write_en), 64'd0);

    // Single load: count 0->1->0, write two cycles after the handshake.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11, 5'd3);
    check("ld_count_1", 64'(bus.lq_count), 64'd1);
    idle(1, 5'd3);
    check("ld_write_addr", 64'(bus.rd_addr), 64'd3);
    check("ld_count_0", 64'(bus.lq_count), 64'd0);

    // Continuous ALU traffic fills the queue; loads 1..5 drain in order once it stops.
    idx = 1;
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 5'd9, 32'h900 + 32'(c), idx <= 5, 5'(idx), 32'h100 + 32'(idx), 5'd1);
      if (m_pushed) idx++;
    end
    check("fill_count", 64'(bus.lq_count), 64'd4);
    for (int c = 0; c < 8; c++) begin
      step(1'b0, 5'd0, 32'd0, idx <= 5, 5'(idx), 32'h100 + 32'(idx), 5'd4);
      if (m_pushed) idx++;
    end
    check("fifth_accepted", 64'(idx), 64'd6);

    // WAW squash: queued load to r7 is overtaken by a younger ALU write to r7.
    step(1'b1, 5'd9, 32'h1, 1'b1, 5'd7, 32'h77, 5'd7);
    step(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 32'd0, 5'd7);
    idle(3, 5'd7);
    // Same-cycle push to the ALU's rd survives.
    step(1'b1, 5'd6, 32'h66, 1'b1, 5'd6, 32'h67, 5'd6);
    idle(2, 5'd6);

    // Writes to r0 are dropped everywhere.
    for (int c = 0; c < 3; c++) step(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE, 5'd0);
    idle(1, 5'd0);

    // Reset with three queued loads and a write in flight.
    for (int c = 0; c < 3; c++) step(1'b1, 5'd12, 32'h12, 1'b1, 5'(20 + c), 32'(c), 5'd20);
    mid_reset();
    idle(3, 5'd20);

    // Random traffic over a small register range so collisions are frequent.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
             5'($urandom_range(0, 7)));
      end
    end
    idle(6, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
